rv_launch_ctrl: RTL and testbench
=================================

Name: rv_launch_ctrl

Overview:
- Host-side launcher that drives the core's run-control handshake.
- Streams a program into instruction BRAM, then holds `core_start` high until the core reports ecall completion (`core_done`) or a timeout expires.
- On completion, reads a window of data BRAM and streams it out.
- Sits between the host interface and the RV32I core top. `core_start` feeds the core's start input; `core_done` comes from its done output.

Parameters:
- IMEM_AW, 10, instruction BRAM word-address width
- DMEM_AW, 10, data BRAM word-address width
- TMO_W, 24, timeout counter width; timeout fires at 2^TMO_W-1 RUN cycles

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_go  in  1  one-cycle launch request; sampled only in IDLE
- prog_len  in  IMEM_AW+1  program length in words, latched on accepted cmd_go
- rd_base  in  DMEM_AW  first data word to return, latched on cmd_go
- rd_len  in  DMEM_AW+1  number of data words to return, latched on cmd_go
- s_valid  in  1  program word valid
- s_data  in  32  program word
- s_ready  out  1  program word accepted when s_valid&&s_ready
- imem_we  out  1  instruction BRAM write enable
- imem_addr  out  IMEM_AW  instruction BRAM word address
- imem_wdata  out  32  instruction BRAM write data
- core_start  out  1  run request to the core, level
- core_done  in  1  core finished (ecall 0x00000073 executed)
- dmem_re  out  1  data BRAM read enable
- dmem_addr  out  DMEM_AW  data BRAM word address
- dmem_rdata  in  32  data BRAM read data, valid 1 cycle after dmem_re
- m_valid  out  1  result word valid
- m_data  out  32  result word
- m_ready  in  1  result word consumed when m_valid&&m_ready
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of every launch
- timeout_err  out  1  sticky; set on timeout, cleared on next accepted cmd_go

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, all counters 0, latched lengths 0.
- Reset mid-operation aborts immediately. `core_start` drops asynchronously and no `done` pulse is issued.
- IDLE:
  - On cmd_go=1, latch prog_len/rd_base/rd_len, clear wcnt, tmr and timeout_err.
  - Next state is LOAD if prog_len!=0, else RUN.
  - cmd_go in any other state is ignored.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid=1 writes combinationally in the same cycle: imem_we=1, imem_addr=wcnt, imem_wdata=s_data. wcnt then increments.
  - When the accepted word is word prog_len-1, the next state is RUN.
  - A transfer accepted on the transition cycle is the last word; s_ready is 0 in RUN.
- RUN:
  - core_start=1 (registered, so high from the first RUN cycle).
  - tmr increments each cycle. core_done is sampled only in RUN.
  - If core_done=1: next state is RD_ISSUE if rd_len!=0, else FIN. core_start goes low on exit.
  - Else if tmr==2^TMO_W-1: set timeout_err, next state FIN.
  - If core_done and the timeout hit in the same cycle, core_done wins and no error is set.
  - core_done held high for multiple cycles counts once.
- Data read, 3 cycles per word minimum, with rcnt starting at 0:
  - RD_ISSUE: dmem_re=1, dmem_addr=rd_base+rcnt (wraps modulo 2^DMEM_AW). Next state RD_WAIT.
  - RD_WAIT: capture dmem_rdata into the m_data register. Next state RD_OUT.
  - RD_OUT: m_valid=1. m_data is held stable until m_ready. On handshake, rcnt increments; next state is FIN if rcnt==rd_len-1, else RD_ISSUE.
- FIN: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- Width rules:
  - prog_len up to 2^IMEM_AW words.
  - Values greater than 2^IMEM_AW are clamped to 2^IMEM_AW on latch; rd_len is clamped the same way to 2^DMEM_AW.

Decomposition:
- Shared package rv_launch_pkg holds:
  - the state enum: IDLE, LOAD, RUN, RD_ISSUE, RD_WAIT, RD_OUT, FIN
  - ECALL_INSN = 32'h00000073
  - default widths
- One natural sub-module: rv_launch_timer, a TMO_W-bit clearable counter with an at-max flag, reused by other host blocks.

Test Plan:
- Reset then idle: rst low 3 cycles → all outputs 0, busy=0. cmd_go asserted during reset has no effect.
- Normal launch: prog_len=4, words 0x00500093, 0x00100113, 0x00000013, 0x00000073 with s_valid continuous.
  - Required: imem writes at addresses 0..3 on 4 consecutive cycles, then core_start=1.
  - Model core_done=1 after 20 cycles; with rd_base=0x10, rd_len=2, expect dmem_addr 0x10 then 0x11.
  - m_data matches BRAM contents; done pulses once; core_start=0 after done.
- Backpressure: same launch with s_valid toggling 1/0 and m_ready low 5 cycles per word.
  - Required: no lost or duplicated words; m_data stable while m_valid && !m_ready.
- Timeout: TMO_W=4, core_done never asserted → timeout_err=1 after 15 RUN cycles, no dmem_re, done pulse, core_start=0.
- Boundaries:
  - prog_len=0, rd_len=0 → IDLE→RUN directly, no s_ready. On core_done, expect FIN, done pulse.
  - rd_base=0x3FF, rd_len=2 → addresses 0x3FF then 0x000.
  - core_done held high for 4 cycles → exactly one done pulse.
- Abort: rst asserted in RD_OUT → core_start, m_valid, busy drop immediately. A following cmd_go launches cleanly with timeout_err=0.

Source files
------------

// File: rtl/rv_launch_pkg.sv
// Shared definitions for the host-side launch controller and its helpers.
package rv_launch_pkg;

    localparam int IMEM_AW_DEF = 10;
    localparam int DMEM_AW_DEF = 10;
    localparam int TMO_W_DEF   = 24;

    // Instruction whose execution makes the core raise its done output.
    localparam logic [31:0] ECALL_INSN = 32'h00000073;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RD_ISSUE,
        RD_WAIT,
        RD_OUT,
        FIN
    } launch_state_e;

endpackage

// File: rtl/rv_launch_timer.sv
// Clearable free-running counter that flags when it sits at its maximum value.
module rv_launch_timer #(
    parameter int W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    // Count enabled cycles; clear takes priority so a fresh launch starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

    assign at_max = &count;

endmodule

// File: rtl/rv_launch_ctrl.sv
// Host launcher: loads a program into IMEM, runs the core, then streams a DMEM window out.
module rv_launch_ctrl
    import rv_launch_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF,
    parameter int DMEM_AW = DMEM_AW_DEF,
    parameter int TMO_W   = TMO_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_go,
    input  logic [IMEM_AW:0]   prog_len,
    input  logic [DMEM_AW-1:0] rd_base,
    input  logic [DMEM_AW:0]   rd_len,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    output logic               s_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_start,
    input  logic               core_done,
    output logic               dmem_re,
    output logic [DMEM_AW-1:0] dmem_addr,
    input  logic [31:0]        dmem_rdata,
    output logic               m_valid,
    output logic [31:0]        m_data,
    input  logic               m_ready,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    localparam logic [IMEM_AW:0] PLEN_MAX = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] PLEN_ONE = (IMEM_AW+1)'(1);
    localparam logic [DMEM_AW:0] RLEN_MAX = {1'b1, {DMEM_AW{1'b0}}};
    localparam logic [DMEM_AW:0] RLEN_ONE = (DMEM_AW+1)'(1);

    launch_state_e state, state_nxt;

    logic [IMEM_AW:0]   prog_len_q;
    logic [DMEM_AW-1:0] rd_base_q;
    logic [DMEM_AW:0]   rd_len_q;
    logic [IMEM_AW:0]   wcnt;
    logic [DMEM_AW:0]   rcnt;
    logic [31:0]        m_data_q;
    logic               core_start_q;
    logic               timeout_q;
    logic               timeout_set;
    logic               tmr_at_max;
    logic               accept;
    logic               last_word;
    logic               last_read;

    assign accept    = (state == IDLE) && cmd_go;
    assign last_word = (wcnt == prog_len_q - PLEN_ONE);
    assign last_read = (rcnt == rd_len_q - RLEN_ONE);

    rv_launch_timer #(
        .W(TMO_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == RUN),
        .at_max (tmr_at_max)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes; core_done beats the timeout in the same cycle.
    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        imem_we     = 1'b0;
        dmem_re     = 1'b0;
        m_valid     = 1'b0;
        done        = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    state_nxt = (prog_len != '0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    imem_we = 1'b1;
                    if (last_word) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    state_nxt = (rd_len_q != '0) ? RD_ISSUE : FIN;
                end else if (tmr_at_max) begin
                    timeout_set = 1'b1;
                    state_nxt   = FIN;
                end
            end
            RD_ISSUE: begin
                dmem_re   = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                state_nxt = RD_OUT;
            end
            RD_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = last_read ? FIN : RD_ISSUE;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch launch parameters, clamping lengths to the memory depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_len_q <= '0;
            rd_base_q  <= '0;
            rd_len_q   <= '0;
        end else if (accept) begin
            prog_len_q <= prog_len[IMEM_AW] ? PLEN_MAX : prog_len;
            rd_base_q  <= rd_base;
            rd_len_q   <= rd_len[DMEM_AW] ? RLEN_MAX : rd_len;
        end
    end

    // Word counters for the program load and the result read-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
            rcnt <= '0;
        end else if (accept) begin
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            if (imem_we) begin
                wcnt <= wcnt + PLEN_ONE;
            end
            if (m_valid && m_ready) begin
                rcnt <= rcnt + RLEN_ONE;
            end
        end
    end

    // Result register, start level and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data_q     <= '0;
            core_start_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            core_start_q <= (state_nxt == RUN);
            if (state == RD_WAIT) begin
                m_data_q <= dmem_rdata;
            end
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign imem_addr   = wcnt[IMEM_AW-1:0];
    assign imem_wdata  = imem_we ? s_data : '0;
    assign dmem_addr   = rd_base_q + rcnt[DMEM_AW-1:0];
    assign m_data      = m_data_q;
    assign core_start  = core_start_q;
    assign timeout_err = timeout_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_rv_launch_ctrl.sv
// Self-checking bench for rv_launch_ctrl: directed table, random launches, timeout and abort sequences.
module tb_rv_launch_ctrl;
    import rv_launch_pkg::*;

    localparam int IAW = 10;
    localparam int DAW = 10;
    localparam int IDEPTH = 1 << IAW;
    localparam int DDEPTH = 1 << DAW;

    typedef struct {
        int plen;
        int base;
        int rlen;
        int dly;
        int hold;
        bit tog;
        int stall;
        bit fixed;
        int exp_w;
        int exp_r;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_go = 1'b0;
    logic [IAW:0]   prog_len = '0;
    logic [DAW-1:0] rd_base = '0;
    logic [DAW:0]   rd_len = '0;
    logic           s_valid = 1'b0;
    logic [31:0]    s_data = '0;
    logic           core_done = 1'b0;
    logic [31:0]    dmem_rdata = '0;
    logic           m_ready = 1'b0;
    logic           s_ready, imem_we, core_start, dmem_re, m_valid, busy, done, timeout_err;
    logic [IAW-1:0] imem_addr;
    logic [31:0]    imem_wdata, m_data;
    logic [DAW-1:0] dmem_addr;

    logic           t_cmd_go = 1'b0;
    logic           t_core_done = 1'b0;
    logic           t_s_ready, t_imem_we, t_core_start, t_dmem_re, t_m_valid, t_busy, t_done, t_timeout_err;
    logic [IAW-1:0] t_imem_addr;
    logic [31:0]    t_imem_wdata, t_m_data;
    logic [DAW-1:0] t_dmem_addr;

    logic [31:0] dmem [DDEPTH];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [IAW-1:0] iw_addr_q[$];
    logic [31:0]    iw_data_q[$];
    int             iw_cyc_q[$];
    logic [DAW-1:0] rd_addr_q[$];
    logic [31:0]    out_q[$];
    int             done_cnt = 0;
    int             sready_cnt = 0;
    int             cs_rise_cyc = -1;
    bit             cs_prev = 1'b0;
    bit             hold_pending = 1'b0;
    logic [31:0]    held_data = '0;

    rv_launch_ctrl dut (
        .clk(clk), .rst(rst), .cmd_go(cmd_go), .prog_len(prog_len), .rd_base(rd_base), .rd_len(rd_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_start(core_start), .core_done(core_done), .dmem_re(dmem_re),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    rv_launch_ctrl #(.TMO_W(4)) tdut (
        .clk(clk), .rst(rst), .cmd_go(t_cmd_go), .prog_len('0), .rd_base('0), .rd_len(rd_len),
        .s_valid(1'b0), .s_data(32'h0), .s_ready(t_s_ready), .imem_we(t_imem_we), .imem_addr(t_imem_addr),
        .imem_wdata(t_imem_wdata), .core_start(t_core_start), .core_done(t_core_done), .dmem_re(t_dmem_re),
        .dmem_addr(t_dmem_addr), .dmem_rdata(32'h0), .m_valid(t_m_valid), .m_data(t_m_data),
        .m_ready(1'b1), .busy(t_busy), .done(t_done), .timeout_err(t_timeout_err)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to measure spacing between observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Data BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (dmem_re) dmem_rdata <= dmem[dmem_addr];
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Mid-cycle monitor: records every transfer and checks output hold under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            hold_pending = 1'b0;
            cs_prev = 1'b0;
        end else begin
            if (imem_we) begin
                iw_addr_q.push_back(imem_addr);
                iw_data_q.push_back(imem_wdata);
                iw_cyc_q.push_back(cyc);
            end
            if (dmem_re) rd_addr_q.push_back(dmem_addr);
            if (s_ready) sready_cnt++;
            if (done) done_cnt++;
            if (core_start && !cs_prev) cs_rise_cyc = cyc;
            cs_prev = core_start;
            if (m_valid) begin
                if (hold_pending) check_output("m_data_stable", m_data, held_data);
                if (m_ready) begin
                    out_q.push_back(m_data);
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    held_data = m_data;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // Runs one launch on the main instance, emulating the host source, core and result sink.
    task automatic apply_stimulus(input vec_t v, input bit abort);
        logic [31:0] prog[$];
        int plen_eff, widx, since, stall, n;
        bit started, fin, hit;
        plen_eff = clamp_len(v.plen, IDEPTH);
        if (v.fixed) begin
            prog = '{32'h00500093, 32'h00100113, 32'h00000013, ECALL_INSN};
        end else begin
            for (int i = 0; i < plen_eff; i++) prog.push_back((i == plen_eff - 1) ? ECALL_INSN : $urandom);
        end
        iw_addr_q.delete(); iw_data_q.delete(); iw_cyc_q.delete(); rd_addr_q.delete(); out_q.delete();
        done_cnt = 0; sready_cnt = 0; cs_rise_cyc = -1;
        prog_len = (IAW+1)'(v.plen); rd_base = DAW'(v.base); rd_len = (DAW+1)'(v.rlen);
        cmd_go = 1'b1;
        @(posedge clk); #1;
        cmd_go = 1'b0;
        widx = 0; since = 0; stall = 0; started = 0; fin = 0; hit = 0;
        for (int c = 0; c < 20000 && !fin && !hit; c++) begin
            s_valid   = (widx < plen_eff) && (!v.tog || (c % 2 == 0));
            s_data    = (widx < plen_eff) ? prog[widx] : 32'h0;
            m_ready   = (stall >= v.stall);
            core_done = started && (since >= v.dly) && (since < v.dly + v.hold);
            @(negedge clk);
            if (s_valid && s_ready) widx++;
            if (started) since++;
            else if (core_start) started = 1;
            if (m_valid && !m_ready) stall++;
            else if (m_valid) stall = 0;
            if (done) fin = 1;
            if (abort && m_valid) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0; core_done = 1'b0;
        if (abort) begin
            check_output("abort_reached_rd_out", hit, 1);
            return;
        end
        m_ready = 1'b0;
        check_output("launch_finished", fin, 1);
        check_output("imem_write_count", iw_addr_q.size(), v.exp_w);
        n = (iw_addr_q.size() < plen_eff) ? iw_addr_q.size() : plen_eff;
        for (int i = 0; i < n; i++) begin
            check_output("imem_addr", iw_addr_q[i], i % IDEPTH);
            check_output("imem_wdata", iw_data_q[i], prog[i]);
        end
        if (plen_eff > 0 && !v.tog && n == plen_eff) begin
            check_output("imem_back_to_back", iw_cyc_q[n-1] - iw_cyc_q[0], plen_eff - 1);
            check_output("core_start_after_load", cs_rise_cyc, iw_cyc_q[n-1] + 1);
        end
        if (plen_eff == 0) check_output("s_ready_never", sready_cnt, 0);
        check_output("dmem_read_count", rd_addr_q.size(), v.exp_r);
        check_output("result_count", out_q.size(), v.exp_r);
        for (int i = 0; i < rd_addr_q.size() && i < v.exp_r; i++) begin
            check_output("dmem_addr", rd_addr_q[i], (v.base + i) % DDEPTH);
        end
        for (int i = 0; i < out_q.size() && i < v.exp_r; i++) begin
            check_output("m_data", out_q[i], dmem[(v.base + i) % DDEPTH]);
        end
        check_output("done_pulses", done_cnt, 1);
        check_output("timeout_err_clear", timeout_err, 0);
        check_output("core_start_low_after", core_start, 0);
        check_output("busy_low_after", busy, 0);
    endtask

    // Runs the small-timer instance with the core either silent or finishing on the limit cycle.
    task automatic timeout_seq(input bit done_at_limit);
        int runc, dre, dones, sr;
        bit tfin;
        rd_len = (DAW+1)'(2);
        t_cmd_go = 1'b1;
        @(posedge clk); #1;
        t_cmd_go = 1'b0;
        runc = 0; dre = 0; dones = 0; sr = 0; tfin = 0;
        for (int c = 0; c < 200 && !tfin; c++) begin
            t_core_done = done_at_limit && (runc == 15);
            @(negedge clk);
            if (t_core_start) runc++;
            if (t_dmem_re) dre++;
            if (t_s_ready) sr++;
            if (t_done) begin
                dones++;
                tfin = 1;
            end
            @(posedge clk); #1;
        end
        t_core_done = 1'b0;
        check_output("t_finished", tfin, 1);
        check_output("t_run_cycles", runc, 16);
        check_output("t_timeout_err", t_timeout_err, !done_at_limit);
        check_output("t_dmem_reads", dre, done_at_limit ? 2 : 0);
        check_output("t_s_ready_never", sr, 0);
        check_output("t_done_pulses", dones, 1);
        check_output("t_core_start_low", t_core_start, 0);
        check_output("t_busy_low", t_busy, 0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;

        for (int i = 0; i < DDEPTH; i++) dmem[i] = $urandom;

        tbl[0] = '{plen:4,    base:'h10,  rlen:2,    dly:20, hold:1, tog:0, stall:0, fixed:1, exp_w:4,    exp_r:2};
        tbl[1] = '{plen:4,    base:'h10,  rlen:2,    dly:20, hold:1, tog:1, stall:5, fixed:1, exp_w:4,    exp_r:2};
        tbl[2] = '{plen:0,    base:'h22,  rlen:0,    dly:3,  hold:1, tog:0, stall:0, fixed:0, exp_w:0,    exp_r:0};
        tbl[3] = '{plen:3,    base:'h3FF, rlen:2,    dly:1,  hold:1, tog:0, stall:1, fixed:0, exp_w:3,    exp_r:2};
        tbl[4] = '{plen:1,    base:'h5,   rlen:2,    dly:2,  hold:4, tog:0, stall:0, fixed:0, exp_w:1,    exp_r:2};
        tbl[5] = '{plen:2047, base:'h200, rlen:2047, dly:0,  hold:1, tog:0, stall:0, fixed:0, exp_w:1024, exp_r:1024};
        tbl[6] = '{plen:1024, base:'h3FE, rlen:1,    dly:5,  hold:2, tog:1, stall:2, fixed:0, exp_w:1024, exp_r:1};

        // Reset with a launch request pending: nothing may start.
        cmd_go = 1'b1; t_cmd_go = 1'b1; prog_len = (IAW+1)'(4);
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ctrl", {s_ready, imem_we, core_start, dmem_re, m_valid, busy, done, timeout_err, imem_addr, dmem_addr}, 0);
        check_output("reset_data", {imem_wdata, m_data}, 0);
        check_output("reset_t_busy", t_busy, 0);
        cmd_go = 1'b0; t_cmd_go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("idle_after_reset", {busy, t_busy, core_start}, 0);

        for (int i = 0; i < 7; i++) apply_stimulus(tbl[i], 1'b0);

        for (int i = 0; i < 10; i++) begin
            rv.plen  = $urandom_range(0, 12);
            rv.base  = $urandom_range(0, DDEPTH - 1);
            rv.rlen  = $urandom_range(0, 6);
            rv.dly   = $urandom_range(0, 30);
            rv.hold  = $urandom_range(1, 4);
            rv.tog   = 1'($urandom_range(0, 1));
            rv.stall = $urandom_range(0, 3);
            rv.fixed = 1'b0;
            rv.exp_w = clamp_len(rv.plen, IDEPTH);
            rv.exp_r = clamp_len(rv.rlen, DDEPTH);
            apply_stimulus(rv, 1'b0);
        end

        timeout_seq(1'b0);
        timeout_seq(1'b1);

        // Abort while a result word is waiting for the sink.
        rv = '{plen:2, base:'h40, rlen:2, dly:4, hold:1, tog:0, stall:100, fixed:0, exp_w:2, exp_r:2};
        done_cnt = 0;
        apply_stimulus(rv, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_outputs", {core_start, m_valid, busy, done}, 0);
        repeat (2) @(negedge clk);
        check_output("abort_no_done", done_cnt, 0);
        m_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rv.stall = 0;
        apply_stimulus(rv, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
